// File: rtl/wm8960_pkg.sv
// Shared types and constants for the WM8960 init sequencer.
// State encoding, soft-reset register address and 50 MHz default delays.
package wm8960_pkg;

    typedef enum logic [3:0] {
        StPwrup,
        StFetch,
        StLatch,
        StIssue,
        StWait,
        StSettle,
        StNext,
        StDone,
        StErr
    } seq_state_t;

    localparam logic [6:0] WM8960_SOFT_RESET_REG = 7'h0F;

    // 10 ms power-up wait and 1 ms soft-reset settle at 50 MHz.
    localparam int unsigned PWRUP_CYCLES_50MHZ   = 500000;
    localparam int unsigned RST_DLY_CYCLES_50MHZ = 50000;

endpackage

// File: rtl/init_delay_cnt.sv
// Free-running delay counter: counts while enabled, pulses tc on the last cycle and rewraps.
// Held at zero whenever clr is set so every delay starts from a clean count.
module init_delay_cnt #(
    parameter int unsigned CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH:0]   cnt_inc;

    // Extra bit keeps the compare safe at the top of the range; limit 0 behaves like 1.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
    assign tc      = en && (cnt_inc >= {1'b0, limit});

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_inc[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/wm8960_init_seq.sv
// Walks the WM8960 init table and feeds each 16-bit entry to the I2C write master,
// with power-up wait, soft-reset settling, NACK retry and restart on request.
module wm8960_init_seq
    import wm8960_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 20,
    parameter logic [CNT_WIDTH-1:0] PWRUP_CYCLES = CNT_WIDTH'(PWRUP_CYCLES_50MHZ),
    parameter logic [CNT_WIDTH-1:0] RST_DLY_CYCLES = CNT_WIDTH'(RST_DLY_CYCLES_50MHZ),
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] tbl_addr,
    input  logic [15:0]           tbl_q,
    input  logic [7:0]            lut_size,
    input  logic [7:0]            dev_id,
    output logic                  i2c_req,
    output logic [7:0]            i2c_dev,
    output logic [7:0]            i2c_byte_hi,
    output logic [7:0]            i2c_byte_lo,
    input  logic                  i2c_done,
    input  logic                  i2c_nack,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err
);

    seq_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] retry_q, retry_d;
    logic       req_q, req_d;
    logic [7:0] dev_q, dev_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;

    logic                 dly_en;
    logic                 dly_tc;
    logic [CNT_WIDTH-1:0] dly_limit;

    assign dly_en    = (state_q == StPwrup) || (state_q == StSettle);
    assign dly_limit = (state_q == StSettle) ? RST_DLY_CYCLES : PWRUP_CYCLES;

    init_delay_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_delay (
        .clk  (clk),
        .reset(reset),
        .clr  (!dly_en),
        .en   (dly_en),
        .limit(dly_limit),
        .tc   (dly_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        req_d   = req_q;
        dev_d   = dev_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            StPwrup: begin
                if (dly_tc) begin
                    idx_d   = 8'd0;
                    retry_d = 8'd0;
                    state_d = (lut_size == 8'd0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                hi_d    = tbl_q[15:8];
                lo_d    = tbl_q[7:0];
                dev_d   = dev_id;
                state_d = StIssue;
            end
            StIssue: begin
                req_d   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (i2c_done) begin
                    req_d = 1'b0;
                    if (i2c_nack) begin
                        // Retries resend the latched payload without touching the table.
                        if (retry_q < 8'(MAX_RETRY)) begin
                            retry_d = retry_q + 8'd1;
                            state_d = StIssue;
                        end else begin
                            state_d = StErr;
                        end
                    end else if (hi_q[7:1] == WM8960_SOFT_RESET_REG) begin
                        state_d = StSettle;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StSettle: begin
                if (dly_tc) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                retry_d = 8'd0;
                if (idx_q == lut_size - 8'd1) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StFetch;
                end
            end
            StDone, StErr: begin
                if (start) begin
                    idx_d   = 8'd0;
                    retry_d = 8'd0;
                    state_d = (lut_size == 8'd0) ? StDone : StFetch;
                end
            end
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StPwrup;
            idx_q   <= 8'd0;
            retry_q <= 8'd0;
            req_q   <= 1'b0;
            dev_q   <= 8'd0;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            dev_q   <= dev_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // idx only changes on the way into FETCH, so the address is stable for the ROM read.
    assign tbl_addr    = ADDR_WIDTH'(idx_q);
    assign i2c_req     = req_q;
    assign i2c_dev     = dev_q;
    assign i2c_byte_hi = hi_q;
    assign i2c_byte_lo = lo_q;
    assign busy        = (state_q != StDone) && (state_q != StErr);
    assign init_done   = (state_q == StDone);
    assign init_err    = (state_q == StErr);

endmodule

// File: tb/tb_wm8960_init_seq.sv
// Directed/randomized bench for wm8960_init_seq: random table contents and I2C response
// latency, expected transfers and gaps computed from the sequencing rules.
module tb_wm8960_init_seq;

    localparam int PWRUP  = 10;
    localparam int RSTDLY = 8;
    localparam int MAXR   = 2;
    localparam int LUT    = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_q = 16'h0;
    logic [7:0]  lut_size = 8'd20;
    logic [7:0]  dev_id = 8'h34;
    logic        i2c_req;
    logic [7:0]  i2c_dev;
    logic [7:0]  i2c_byte_hi;
    logic [7:0]  i2c_byte_lo;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        busy;
    logic        init_done;
    logic        init_err;

    logic [15:0] rom [256];
    int          cyc = 0;
    int          t_ref = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  exp_vol;

    wm8960_init_seq #(
        .ADDR_WIDTH    (8),
        .CNT_WIDTH     (20),
        .PWRUP_CYCLES  (20'(PWRUP)),
        .RST_DLY_CYCLES(20'(RSTDLY)),
        .MAX_RETRY     (MAXR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tbl_addr   (tbl_addr),
        .tbl_q      (tbl_q),
        .lut_size   (lut_size),
        .dev_id     (dev_id),
        .i2c_req    (i2c_req),
        .i2c_dev    (i2c_dev),
        .i2c_byte_hi(i2c_byte_hi),
        .i2c_byte_lo(i2c_byte_lo),
        .i2c_done   (i2c_done),
        .i2c_nack   (i2c_nack),
        .busy       (busy),
        .init_done  (init_done),
        .init_err   (init_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tbl_q <= rom[tbl_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_table(input logic [7:0] vol);
        rom[0] = 16'h1E00;
        for (int i = 1; i < 18; i++) rom[i] = 16'($urandom);
        rom[18] = {7'h02, 1'b1, vol};
        rom[19] = {7'h03, 1'b1, vol};
        exp_vol = vol;
    endtask

    // gap is counted from the negedge at which the triggering input was driven.
    task automatic expect_req(input string tag, input int gap, input logic [15:0] word);
        int seen;
        seen = -1;
        for (int k = 0; k < gap + 40; k++) begin
            @(negedge clk);
            if (i2c_req === 1'b1) begin
                seen = cyc - t_ref;
                break;
            end
        end
        chk({tag, ".gap"}, seen, gap);
        chk({tag, ".pay"}, {i2c_dev, i2c_byte_hi, i2c_byte_lo}, {dev_id, word});
    endtask

    task automatic respond(input bit nack, input int hold, input logic [15:0] word);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold", {i2c_req, i2c_byte_hi, i2c_byte_lo}, {1'b1, word});
        end
        i2c_done = 1'b1;
        i2c_nack = nack;
        t_ref = cyc;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        chk("req_drop", i2c_req, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t_ref = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic count_idle_reqs(input string tag);
        int n;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i2c_req === 1'b1) n++;
        end
        chk(tag, n, 0);
    endtask

    // Expected behaviour: every entry in order, each retried after a NACK up to MAXR
    // extra times; done->next request is 4 edges (+RSTDLY after register 0x0F), a retry
    // is 1 edge; +1 because the done pulse is driven half a cycle before it is sampled.
    task automatic run_seq(input int first_gap, input int nack_entry, input int nack_times,
                           input int start_at, input int reset_at);
        int gap;
        bit nack;
        gap = first_gap;
        for (int i = 0; i < LUT; i++) begin
            for (int a = 0; a <= MAXR; a++) begin
                expect_req($sformatf("e%0d.a%0d", i, a), gap, rom[i]);
                if (i >= 18) chk($sformatf("vol%0d", i), i2c_byte_lo, exp_vol);
                if (i == reset_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    chk("rst_mid", {i2c_req, busy, init_done, init_err, tbl_addr, i2c_dev,
                                    i2c_byte_hi, i2c_byte_lo}, {4'b0100, 32'h0});
                    reset = 1'b0;
                    t_ref = cyc;
                    return;
                end
                if (i == start_at && a == 0) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    chk("start_busy", {busy, i2c_req}, 2'b11);
                end
                nack = (i == nack_entry) && (a < nack_times);
                respond(nack, $urandom_range(0, 3), rom[i]);
                if (!nack) break;
                if (a == MAXR) begin
                    repeat (2) @(negedge clk);
                    chk("err_state", {init_err, init_done, busy}, 3'b100);
                    chk("err_addr", tbl_addr, nack_entry);
                    count_idle_reqs("err_no_req");
                    return;
                end
                gap = 2;
            end
            gap = (rom[i][15:9] == 7'h0F) ? 5 + RSTDLY : 5;
        end
        repeat (2) @(negedge clk);
        chk("done_state", {init_done, init_err, busy}, 3'b100);
        count_idle_reqs("done_no_req");
    endtask

    initial begin
        fill_table(8'h79);
        repeat (3) @(negedge clk);
        chk("reset_state", {i2c_req, busy, init_done, init_err, tbl_addr, i2c_dev,
                            i2c_byte_hi, i2c_byte_lo}, {4'b0100, 32'h0});

        // Power-up run, all ACK.
        reset = 1'b0;
        t_ref = cyc;
        run_seq(PWRUP + 3, -1, 0, -1, -1);

        // Stray done outside WAIT has no effect.
        i2c_done = 1'b1;
        i2c_nack = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        @(negedge clk);
        chk("stray_done", {init_done, init_err, busy}, 3'b100);

        // Re-init with new volume, plus an ignored start mid-sequence.
        fill_table(8'hF0);
        pulse_start();
        run_seq(4, -1, 0, 3, -1);

        // Two NACKs on entry 5 recover.
        fill_table(8'hF0);
        pulse_start();
        run_seq(4, 5, 2, -1, -1);

        // Three NACKs on entry 5 exhaust retries.
        pulse_start();
        run_seq(4, 5, 3, -1, -1);

        // Restart from ERR, reset while entry 7 is in flight, then full power-up run.
        dev_id = 8'h1A;
        fill_table(8'($urandom));
        pulse_start();
        run_seq(4, -1, 0, -1, 7);
        run_seq(PWRUP + 3, -1, 0, -1, -1);

        // Empty table: power-up goes straight to DONE with no request.
        lut_size = 8'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        begin
            int n;
            n = 0;
            for (int k = 0; k < PWRUP + 2; k++) begin
                @(negedge clk);
                if (i2c_req === 1'b1) n++;
            end
            chk("empty_no_req", n, 0);
            chk("empty_done", {init_done, init_err, busy}, 3'b100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wm8960_init_seq.md
Name: wm8960_init_seq

Overview:
Sequencer directly downstream of the WM8960 init register table. Walks table entries 0..lut_size-1, waits out the table's 1-cycle read latency, and splits each 16-bit word into two I2C payload bytes. Hands each entry to the I2C write master with a req/done handshake. Handles power-up delay, post-soft-reset settling, NACK retry and re-init requests (e.g. after a volume or BCLK change).

Parameters:
ADDR_WIDTH, 8, table address width
PWRUP_CYCLES, 20'd500000, idle cycles after reset before the first write (10 ms at 50 MHz)
RST_DLY_CYCLES, 20'd50000, settle cycles after writing register 0x0F (soft reset)
MAX_RETRY, 2, extra attempts per entry after a NACK
CNT_WIDTH, 20, delay counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  1-cycle pulse: re-run the full table
tbl_addr  out  ADDR_WIDTH  table address
tbl_q  in  16  table word {reg[6:0], data[8:0]}, valid 1 cycle after tbl_addr
lut_size  in  8  number of entries
dev_id  in  8  8-bit I2C write address
i2c_req  out  1  write request, held until i2c_done
i2c_dev  out  8  device address for the transfer
i2c_byte_hi  out  8  tbl_q[15:8]
i2c_byte_lo  out  8  tbl_q[7:0]
i2c_done  in  1  1-cycle pulse: transfer finished
i2c_nack  in  1  sampled with i2c_done; 1 = NACK
busy  out  1  sequence in progress
init_done  out  1  all entries written OK
init_err  out  1  retries exhausted

Behaviour:
- Reset values: tbl_addr=0, i2c_req=0, i2c_dev/i2c_byte_hi/i2c_byte_lo=0, busy=1, init_done=0, init_err=0. State is PWRUP, counter=0. The sequence runs automatically out of reset.
- States: PWRUP, FETCH, LATCH, ISSUE, WAIT, SETTLE, NEXT, DONE, ERR.
- PWRUP: count to PWRUP_CYCLES-1, then go to FETCH with idx=0 and retry=0.
- FETCH: drive tbl_addr=idx, then go to LATCH. This spends exactly one cycle for the ROM latency.
- LATCH: register tbl_q into i2c_byte_hi/lo and dev_id into i2c_dev, then go to ISSUE.
- ISSUE: assert i2c_req=1, then go to WAIT.
  - i2c_req stays high until the i2c_done cycle and drops on the following cycle.
  - Payload outputs are stable for the whole time req is high.
- WAIT, on i2c_done:
  - nack=1 and retry<MAX_RETRY: retry++, back to ISSUE. The latched payload is reused; no re-fetch.
  - nack=1 and retry==MAX_RETRY: go to ERR.
  - nack=0 and i2c_byte_hi[7:1]==7'h0F: go to SETTLE.
  - nack=0 otherwise: go to NEXT.
- SETTLE: count to RST_DLY_CYCLES-1, then go to NEXT.
- NEXT: retry=0. If idx==lut_size-1, go to DONE; else idx++ and go to FETCH.
- lut_size==0: PWRUP goes straight to DONE. No request is issued.
- DONE: busy=0, init_done=1.
- ERR: busy=0, init_err=1, tbl_addr holds the failing index.
- start:
  - Honoured only in DONE or ERR.
  - Clears init_done/init_err, sets busy=1, and goes to FETCH with idx=0. No power-up delay is repeated.
  - Ignored while busy.
- i2c_done outside WAIT is ignored.
- Reset asserted mid-transfer drops i2c_req on the next edge and restarts from PWRUP. The I2C master shares the same reset.
- Entry count is 8-bit; idx compares in 8 bits and is zero-extended to ADDR_WIDTH.

Decomposition:
- Package wm8960_pkg:
  - State encoding constants.
  - WM8960_SOFT_RESET_REG=7'h0F.
  - Default cycle counts for 50 MHz.
- One sub-module, init_delay_cnt: load/count/terminal-count pulse, shared by PWRUP and SETTLE.

Test Plan:
- Reset, PWRUP_CYCLES=10, lut_size=20, I2C model always ACKs -> first i2c_req rises 10+3 cycles after reset release. Exactly 20 transfers occur; transfer 0 is hi=8'h1E lo=8'h00. init_done=1 and busy=0 after the 20th done.
- Entry 0 is reg 0x0F, RST_DLY_CYCLES=8 -> gap from done#0 to req#1 is 8+4 cycles. For other entries the gap is 4 cycles.
- NACK on entry 5 twice, then ACK -> 3 requests with an identical payload, then entry 6 proceeds; init_done=1.
- NACK on entry 5 three times with MAX_RETRY=2 -> init_err=1, busy=0, tbl_addr=5, no further requests.
- From DONE, pulse start with volume changed to 8'hF0 -> full rerun without power-up delay; entries 18 and 19 carry lo=8'hF0. A start pulse mid-sequence is ignored.
- Assert reset while i2c_req=1 on entry 7 -> req low the next cycle, all outputs at reset values, sequence restarts from PWRUP at entry 0.
